array_result_drain: RTL

Downstream readout stage for the PE array. Once the array controller raises its finish flag, this block sweeps every PE's result RAM in PE-major order. It drives the array's PE-select and register-address inputs and captures the 16-bit read data returned one cycle later. It emits the words as a valid/ready stream with a last marker, so a host interface or UART framer can consume array results without knowing the array geometry.

---
 rtl/array_result_drain_pkg.sv | 17 +
 rtl/array_result_drain_fifo2.sv | 61 ++++++
 rtl/array_result_drain.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/array_result_drain_pkg.sv
// Shared types and constants for the PE-array result drain.
package array_result_drain_pkg;
  localparam int FIFO_DEPTH = 2;
  localparam int DATA_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    FLUSH
  } drain_state_e;

  // One buffered output beat: data word plus end-of-drain marker.
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;
endpackage

// File: rtl/array_result_drain_fifo2.sv
// drain_fifo2: 2-entry synchronous FIFO with occupancy count.
// Push while full is accepted only when a pop happens in the same cycle.
module drain_fifo2
  import array_result_drain_pkg::*;
#(
  parameter int W = DATA_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [1:0]   count,
  output logic         empty,
  output logic         full
);
  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign do_pop  = pop & (cnt_q != 2'd0);
  assign do_push = push & ((cnt_q != 2'(FIFO_DEPTH)) | do_pop);

  assign rdata = mem_q[rd_ptr_q];
  assign count = cnt_q;
  assign empty = (cnt_q == 2'd0);
  assign full  = (cnt_q == 2'(FIFO_DEPTH));

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  // Storage registers; cleared on reset so the head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/array_result_drain.sv
// array_result_drain: sweeps every PE result RAM in PE-major order and
// streams the words out as valid/ready beats with a last marker.
// Optional macro DRAIN_CHECKSUM_EN appends a 16-bit XOR checksum beat.
module array_result_drain
  import array_result_drain_pkg::*;
#(
  parameter int SIZE   = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              drain_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic [SIZE-1:0]   pe_addr,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);
`ifdef DRAIN_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam int              PE_NUM  = SIZE * SIZE;
  localparam logic [SIZE-1:0] PE_LAST = SIZE'(PE_NUM - 1);

  drain_state_e      state_q, state_d;
  logic [SIZE-1:0]   pe_cnt_q, pe_cnt_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [SIZE-1:0]   pe_addr_q, pe_addr_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic              inflight_q, inflight_d;
  logic              infl_last_q, infl_last_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              csum_pend_q, csum_pend_d;

  logic              credit_ok, pop, csum_push;
  logic              fifo_push, fifo_empty, fifo_full;
  logic [1:0]        fifo_count;
  beat_t             push_beat, head_beat;

  assign pop = m_valid & m_ready;

  // Issue only if the word it fetches is guaranteed a FIFO slot.
  assign credit_ok = ({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

  // Read data returns the cycle after the address; the checksum beat only
  // enters once no read is in flight, so the two never collide.
  assign fifo_push = inflight_q | csum_push;
  always_comb begin
    push_beat = '{last: 1'b1, data: csum_q};
    if (inflight_q) begin
      push_beat = '{last: infl_last_q, data: rd_data};
    end
  end

  drain_fifo2 #(.W($bits(beat_t))) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (fifo_push),
    .wdata (push_beat),
    .pop   (pop),
    .rdata (head_beat),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign m_valid  = ~fifo_empty;
  assign m_data   = head_beat.data;
  assign m_last   = m_valid & head_beat.last;
  assign pe_addr  = pe_addr_q;
  assign reg_addr = reg_addr_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  // Sweep FSM: address generation, credit gating and completion.
  always_comb begin
    state_d     = state_q;
    pe_cnt_d    = pe_cnt_q;
    word_cnt_d  = word_cnt_q;
    base_d      = base_q;
    count_d     = count_q;
    pe_addr_d   = pe_addr_q;
    reg_addr_d  = reg_addr_q;
    inflight_d  = 1'b0;
    infl_last_d = 1'b0;
    done_d      = 1'b0;
    csum_d      = csum_q;
    csum_pend_d = csum_pend_q;
    csum_push   = 1'b0;
    if (inflight_q) begin
      csum_d = csum_q ^ rd_data;
    end
    case (state_q)
      IDLE: begin
        if (drain_start) begin
          base_d     = base_addr;
          count_d    = word_count;
          pe_cnt_d   = '0;
          word_cnt_d = '0;
          csum_d     = '0;
          if (word_count == '0) begin
            if (CSUM_EN) begin
              state_d     = FLUSH;
              csum_pend_d = 1'b1;
            end else begin
              done_d = 1'b1;
            end
          end else begin
            state_d     = ISSUE;
            csum_pend_d = CSUM_EN;
          end
        end
      end
      ISSUE: begin
        if (credit_ok) begin
          inflight_d = 1'b1;
          pe_addr_d  = pe_cnt_q;
          reg_addr_d = base_q + word_cnt_q;
          if (word_cnt_q == count_q - 1'b1) begin
            word_cnt_d = '0;
            if (pe_cnt_q == PE_LAST) begin
              state_d     = FLUSH;
              infl_last_d = ~CSUM_EN;
            end else begin
              pe_cnt_d = pe_cnt_q + 1'b1;
            end
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (csum_pend_q && !inflight_q && !fifo_full) begin
          csum_push   = 1'b1;
          csum_pend_d = 1'b0;
        end
        if (pop && head_beat.last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and address registers; reset aborts any drain in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pe_cnt_q    <= '0;
      word_cnt_q  <= '0;
      base_q      <= '0;
      count_q     <= '0;
      pe_addr_q   <= '0;
      reg_addr_q  <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
      csum_q      <= '0;
      csum_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pe_cnt_q    <= pe_cnt_d;
      word_cnt_q  <= word_cnt_d;
      base_q      <= base_d;
      count_q     <= count_d;
      pe_addr_q   <= pe_addr_d;
      reg_addr_q  <= reg_addr_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
      csum_q      <= csum_d;
      csum_pend_q <= csum_pend_d;
    end
  end
endmodule
